stack_op_sequencer: RTL

- Command-driven execution stage directly upstream of the 8-bit, 1024-deep operand LIFO in the stack-machine datapath.
- Accepts one stack-machine opcode per valid/ready handshake and drives the LIFO push/pop strobes.
- Sequences operand pops, computes the result, and pushes results back.
- Reports completion, errors and OUT data to the instruction decoder.

---
 rtl/stack_op_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/stack_op_sequencer.sv
// Stack-machine execution stage: takes one opcode per handshake, sequences
// LIFO pops/pushes, computes the result and reports DONE/ERR/OUT.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   CMD_VALID/READY/OP/IMM         command handshake from the decoder
//   STK_FULL/EMPTY                 LIFO status flags
//   STK_PUSH/PUSH_DATA             LIFO push strobe and data
//   STK_POP/POP_VALID/POP_DATA     LIFO pop strobe, returned word one cycle later
//   DONE/ERR/ERR_CODE              completion pulse, error pulse, held error code
//   OUT_VALID/OUT_DATA             OUT opcode result pulse and held value
module stack_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [OP_W-1:0]   CMD_OP,
    input  logic [DATA_W-1:0] CMD_IMM,
    input  logic              STK_FULL,
    input  logic              STK_EMPTY,
    output logic              STK_PUSH,
    output logic [DATA_W-1:0] STK_PUSH_DATA,
    output logic              STK_POP,
    input  logic              STK_POP_VALID,
    input  logic [DATA_W-1:0] STK_POP_DATA,
    output logic              DONE,
    output logic              ERR,
    output logic [1:0]        ERR_CODE,
    output logic              OUT_VALID,
    output logic [DATA_W-1:0] OUT_DATA
);

    localparam logic [OP_W-1:0] OP_PUSHI = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_EQ    = OP_W'(7);
    localparam logic [OP_W-1:0] OP_LTU   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_DUP   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_DROP  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_OUT   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_SWAP  = OP_W'(12);

    typedef enum logic [3:0] {
        IDLE, POP_A, WAIT_A, POP_B, WAIT_B,
        PUSH_1, PUSH_2, RESTORE, FINISH
    } state_t;

    state_t            state, state_n;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] imm, a, b, alu;
    logic [1:0]        err_code;
    logic              err_set;
    logic [1:0]        err_val;
    logic              accept;
    logic              cmd_pops, op_pushes, op_two_push;

    assign accept      = CMD_VALID && CMD_READY;
    assign cmd_pops    = (CMD_OP >= OP_ADD) && (CMD_OP <= OP_SWAP);
    assign op_pushes   = (op != OP_DROP) && (op != OP_OUT) &&
                         (op >= OP_PUSHI) && (op <= OP_SWAP);
    assign op_two_push = (op == OP_DUP) || (op == OP_SWAP);
    assign ERR_CODE    = err_code;

    always_comb begin
        alu = '0;
        unique case (op)
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            OP_EQ:   alu = DATA_W'(a == b);
            OP_LTU:  alu = DATA_W'(a < b);
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_n       = state;
        CMD_READY     = 1'b0;
        STK_PUSH      = 1'b0;
        STK_PUSH_DATA = '0;
        STK_POP       = 1'b0;
        DONE          = 1'b0;
        ERR           = 1'b0;
        OUT_VALID     = 1'b0;
        err_set       = 1'b0;
        err_val       = 2'd0;
        unique case (state)
            IDLE: begin
                CMD_READY = 1'b1;
                // NOP/illegal also pass through PUSH_1 (without pushing)
                // so that every no-pop command finishes two cycles after accept.
                if (CMD_VALID)
                    state_n = cmd_pops ? POP_A : PUSH_1;
            end
            POP_A: begin
                if (STK_EMPTY) begin
                    err_set = 1'b1;
                    err_val = 2'd1;
                    state_n = FINISH;
                end else begin
                    STK_POP = 1'b1;
                    state_n = WAIT_A;
                end
            end
            WAIT_A: begin
                if (!STK_POP_VALID) begin
                    err_set = 1'b1;
                    err_val = 2'd1;
                    state_n = FINISH;
                end else if (op == OP_DROP || op == OP_OUT) begin
                    state_n = FINISH;
                end else if (op == OP_DUP) begin
                    state_n = PUSH_1;
                end else begin
                    state_n = POP_B;
                end
            end
            POP_B: begin
                if (STK_EMPTY) begin
                    err_set = 1'b1;
                    err_val = 2'd1;
                    state_n = RESTORE;
                end else begin
                    STK_POP = 1'b1;
                    state_n = WAIT_B;
                end
            end
            WAIT_B: begin
                if (!STK_POP_VALID) begin
                    err_set = 1'b1;
                    err_val = 2'd1;
                    state_n = RESTORE;
                end else begin
                    state_n = PUSH_1;
                end
            end
            PUSH_1: begin
                if (!op_pushes) begin
                    state_n = FINISH;
                end else if (STK_FULL) begin
                    err_set = 1'b1;
                    err_val = 2'd2;
                    state_n = FINISH;
                end else begin
                    STK_PUSH = 1'b1;
                    if (op == OP_PUSHI)
                        STK_PUSH_DATA = imm;
                    else if (op_two_push)
                        STK_PUSH_DATA = b;
                    else
                        STK_PUSH_DATA = alu;
                    state_n = op_two_push ? PUSH_2 : FINISH;
                end
            end
            PUSH_2: begin
                if (STK_FULL) begin
                    err_set = 1'b1;
                    err_val = 2'd2;
                end else begin
                    STK_PUSH      = 1'b1;
                    STK_PUSH_DATA = (op == OP_SWAP) ? a : b;
                end
                state_n = FINISH;
            end
            RESTORE: begin
                // b came off a non-full stack, so putting it back cannot overflow
                STK_PUSH      = 1'b1;
                STK_PUSH_DATA = b;
                state_n       = FINISH;
            end
            FINISH: begin
                DONE      = 1'b1;
                ERR       = (err_code != 2'd0);
                OUT_VALID = (op == OP_OUT) && (err_code == 2'd0);
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Quiet every strobe during the reset cycle, whatever the old state.
        if (RST) begin
            CMD_READY = 1'b0;
            STK_PUSH  = 1'b0;
            STK_POP   = 1'b0;
            DONE      = 1'b0;
            ERR       = 1'b0;
            OUT_VALID = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            op       <= '0;
            imm      <= '0;
            a        <= '0;
            b        <= '0;
            err_code <= 2'd0;
            OUT_DATA <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op       <= CMD_OP;
                imm      <= CMD_IMM;
                err_code <= (CMD_OP > OP_SWAP) ? 2'd3 : 2'd0;
            end else if (err_set) begin
                err_code <= err_val;
            end
            if (state == WAIT_A && STK_POP_VALID) begin
                b <= STK_POP_DATA;
                if (op == OP_OUT)
                    OUT_DATA <= STK_POP_DATA;
            end
            if (state == WAIT_B && STK_POP_VALID)
                a <= STK_POP_DATA;
        end
    end

endmodule
